l8_pkt_arb2: RTL and testbench
==============================

// Module: l8_pkt_arb2
// PURPOSE
//  - 2:1 packet-granular arbiter for 64-bit l8 Avalon-ST streams; merges two sources (e.g. ICMP reply gen, ARP responder) ahead of l8_pkt_buf.
//  - Grants one whole packet (sop..eop) at a time; round-robin between requesters; single registered output stage.
// PARAMETERS
//  - DATA_W   64  beat data width
//  - EMPTY_W  3   empty-byte count width (log2(DATA_W/8))
// PORTS
//  - clk                     in   1        clock
//  - xrst                    in   1        async reset, active low
//  - in0_data/in1_data       in   DATA_W   source beat data
//  - in0_startofpacket/in1_* in   1        first beat of packet
//  - in0_endofpacket/in1_*   in   1        last beat of packet
//  - in0_empty/in1_empty     in   EMPTY_W  unused bytes on eop beat
//  - in0_valid/in1_valid     in   1        source beat valid
//  - in0_ready/in1_ready     out  1        beat accepted when valid&ready
//  - to_l8_data              out  DATA_W   merged beat data
//  - to_l8_startofpacket     out  1        merged sop
//  - to_l8_endofpacket       out  1        merged eop
//  - to_l8_empty             out  EMPTY_W  merged empty
//  - to_l8_valid             out  1        merged valid
//  - to_l8_ready             in   1        sink ready
//  - grant_idx               out  1        port currently owning/last owning output
// BEHAVIOUR
//  - Reset: all outputs 0 (to_l8_valid=0, inN_ready=0, grant_idx=0); FSM=IDLE; last_grant=1 (port0 wins first tie).
//  - Output reg advance: out_adv = ~to_l8_valid | to_l8_ready. Beat loads output regs on next edge; latency 1 cycle in->out.
//  - inN_ready = (state==LOCKN) & out_adv (combinational); never asserted in IDLE for sop beats.
//  - FSM IDLE: req0 = in0_valid & in0_startofpacket, likewise req1.
//    - one req -> LOCK of that port next cycle; both -> port != last_grant; none -> stay.
//    - grant updates last_grant and grant_idx at the same edge.
//  - LOCKN: forward beats of port N; on accepted beat with eop -> IDLE next cycle. Other port ready=0 throughout.
//  - Single-beat packet (sop&eop): LOCKN one accepted beat, back to IDLE.
//  - Arbitration bubble: 1 cycle IDLE between packets (no back-to-back grant); acceptable, ≤1 bubble/packet.
//  - Orphan beat: valid without sop on a non-locked port while IDLE -> not granted; ready stays 0 (source stalls; no drop).
//  - Sink backpressure: to_l8_valid&~to_l8_ready holds all output regs stable; inN_ready=0.
//  - to_l8_valid clears on edge when out_adv and no beat accepted.
//  - Source valid drop mid-packet: stay LOCKN, output drains, wait; no timeout.
//  - Reset mid-packet: immediate return to reset values; partial packet truncated downstream (l8_pkt_buf fill unaffected).
//  - Data/sop/eop/empty passed bit-exact; no width conversion.
// CONFIGURATION
//  - L8_PKT_ARB_STRICT_PRIO_EN defined: IDLE tie always grants port0; last_grant ignored (port1 may starve).
//  - Undefined (default): round-robin as above; with both ports continuously requesting, grants alternate 0,1,0,1.
// TESTING
//  - Reset, then in0 3-beat pkt (sop beat 0xA0, eop empty=3), sink ready=1 -> to_l8 beats appear 2 cycles after in0_valid, empty=3 on eop.
//  - in0 and in1 both present sop same cycle after reset -> port0 pkt fully, then port1; second tie -> port1 first (RR).
//  - Same tie with L8_PKT_ARB_STRICT_PRIO_EN -> port0 granted on both ties.
//  - to_l8_ready=0 for 5 cycles mid-packet -> output beat held unchanged, inN_ready=0, no beat lost/duplicated.
//  - in1 sends beat without sop while idle -> in1_ready stays 0, no output; in0 pkt still granted.
//  - xrst low during 4-beat pkt beat 2 -> to_l8_valid=0 next, FSM IDLE, new pkt after reset passes intact.

Source files
------------

// File: rtl/l8_pkt_arb2.sv
// 2:1 packet-granular round-robin arbiter for l8 Avalon-ST streams.
// Define L8_PKT_ARB_STRICT_PRIO_EN for fixed port0 priority on ties.
module l8_pkt_arb2 #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               in1_valid,
  output logic               in1_ready,
  output logic [DATA_W-1:0]  to_l8_data,
  output logic               to_l8_startofpacket,
  output logic               to_l8_endofpacket,
  output logic [EMPTY_W-1:0] to_l8_empty,
  output logic               to_l8_valid,
  input  logic               to_l8_ready,
  output logic               grant_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               last_q, last_d;
  logic               gidx_q, gidx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic               valid_q, valid_d;

  logic out_adv;
  logic acc0, acc1;
  logic req0, req1;
  logic pick;

  assign out_adv   = ~valid_q | to_l8_ready;
  assign in0_ready = (state_q == LOCK0) & out_adv;
  assign in1_ready = (state_q == LOCK1) & out_adv;
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;
  assign req0      = in0_valid & in0_startofpacket;
  assign req1      = in1_valid & in1_startofpacket;

  // Tie winner: the port that did not win last time.
`ifdef L8_PKT_ARB_STRICT_PRIO_EN
  assign pick = 1'b0;
`else
  assign pick = ~last_q;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    unique case (state_q)
      IDLE: begin
        if (req0 & req1) begin
          state_d = pick ? LOCK1 : LOCK0;
          last_d  = pick;
          gidx_d  = pick;
        end else if (req0) begin
          state_d = LOCK0;
          last_d  = 1'b0;
          gidx_d  = 1'b0;
        end else if (req1) begin
          state_d = LOCK1;
          last_d  = 1'b1;
          gidx_d  = 1'b1;
        end
      end
      LOCK0: begin
        if (acc0 & in0_endofpacket)
          state_d = IDLE;
      end
      LOCK1: begin
        if (acc1 & in1_endofpacket)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    valid_d = valid_q;
    if (out_adv) begin
      valid_d = acc0 | acc1;
      unique case (1'b1)
        acc0: begin
          data_d  = in0_data;
          sop_d   = in0_startofpacket;
          eop_d   = in0_endofpacket;
          empty_d = in0_empty;
        end
        acc1: begin
          data_d  = in1_data;
          sop_d   = in1_startofpacket;
          eop_d   = in1_endofpacket;
          empty_d = in1_empty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gidx_q  <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
    end
  end

  assign to_l8_data          = data_q;
  assign to_l8_startofpacket = sop_q;
  assign to_l8_endofpacket   = eop_q;
  assign to_l8_empty         = empty_q;
  assign to_l8_valid         = valid_q;
  assign grant_idx           = gidx_q;

endmodule

// File: tb/tb_l8_pkt_arb2.sv
// Bench for l8_pkt_arb2: IDLE arbitration table plus scoreboarded
// packet sequences (latency, ties, backpressure, orphan, reset).
module tb_l8_pkt_arb2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  typedef struct {
    logic v0, s0, v1, s1;
    logic er0, er1, eg;
  } vec_t;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic [63:0] in0_data = '0, in1_data = '0;
  logic        in0_sop = 0, in0_eop = 0, in1_sop = 0, in1_eop = 0;
  logic [2:0]  in0_empty = '0, in1_empty = '0;
  logic        in0_valid = 0, in1_valid = 0;
  logic        in0_ready, in1_ready;
  logic [63:0] to_l8_data;
  logic        to_l8_sop, to_l8_eop;
  logic [2:0]  to_l8_empty;
  logic        to_l8_valid;
  logic        to_l8_ready = 1'b1;
  logic        grant_idx;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b1;
  beat_t exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  l8_pkt_arb2 dut (
    .clk(clk), .xrst(xrst),
    .in0_data(in0_data), .in0_startofpacket(in0_sop),
    .in0_endofpacket(in0_eop), .in0_empty(in0_empty),
    .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_startofpacket(in1_sop),
    .in1_endofpacket(in1_eop), .in1_empty(in1_empty),
    .in1_valid(in1_valid), .in1_ready(in1_ready),
    .to_l8_data(to_l8_data), .to_l8_startofpacket(to_l8_sop),
    .to_l8_endofpacket(to_l8_eop), .to_l8_empty(to_l8_empty),
    .to_l8_valid(to_l8_valid), .to_l8_ready(to_l8_ready),
    .grant_idx(grant_idx)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: handshake decided just before each rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (mon_en && xrst && to_l8_valid && to_l8_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got beat %0h expected none", to_l8_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("sb_data", to_l8_data, e.data);
        chk("sb_ctl", {59'd0, to_l8_sop, to_l8_eop, to_l8_empty},
            {59'd0, e.sop, e.eop, e.empty});
      end
    end
  end

  function automatic beat_t mk(input logic [63:0] base, input int i,
                               input int n, input logic [2:0] emp);
    beat_t b;
    b.data  = base + 64'(i);
    b.sop   = (i == 0);
    b.eop   = (i == n - 1);
    b.empty = (i == n - 1) ? emp : 3'd0;
    return b;
  endfunction

  task automatic push_pkt(input logic [63:0] base, input int n,
                          input logic [2:0] emp);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(base, i, n, emp));
  endtask

  task automatic drive(input bit p, input beat_t b, input logic v);
    if (p) begin
      in1_data = b.data; in1_sop = b.sop; in1_eop = b.eop;
      in1_empty = b.empty; in1_valid = v;
    end else begin
      in0_data = b.data; in0_sop = b.sop; in0_eop = b.eop;
      in0_empty = b.empty; in0_valid = v;
    end
  endtask

  // Entered at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input bit p, input beat_t b);
    bit acc = 1'b0;
    int n = 0;
    drive(p, b, 1'b1);
    while (!acc && n < 200) begin
      #4;
      acc = p ? in1_ready : in0_ready;
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: port %0d beat %0h never accepted", p, b.data);
    end
  endtask

  task automatic send_pkt(input bit p, input logic [63:0] base,
                          input int n, input logic [2:0] emp);
    for (int i = 0; i < n; i++) send_beat(p, mk(base, i, n, emp));
    drive(p, '0, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    xrst = 1'b0;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    to_l8_ready = 1'b1;
    repeat (2) @(negedge clk);
    xrst = 1'b1;
  endtask

  initial begin
    bit bad;
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 1, 0, 0};
    vecs[2] = '{0, 0, 1, 1, 0, 1, 1};
    vecs[3] = '{1, 1, 1, 1, 1, 0, 0};
    vecs[4] = '{0, 0, 1, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 1, 1, 0, 1, 1};

    do_reset();
    #1;
    chk("rst_valid", 64'(to_l8_valid), 64'd0);
    chk("rst_ready", {62'd0, in1_ready, in0_ready}, 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);

    // IDLE arbitration decisions from the reset state.
    mon_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      in0_valid = vecs[k].v0; in0_sop = vecs[k].s0;
      in1_valid = vecs[k].v1; in1_sop = vecs[k].s1;
      #1;
      chk($sformatf("tbl%0d_idle_rdy", k), {62'd0, in1_ready, in0_ready}, 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_rdy", k), {62'd0, in1_ready, in0_ready},
          {62'd0, vecs[k].er1, vecs[k].er0});
      chk($sformatf("tbl%0d_gnt", k), 64'(grant_idx), 64'(vecs[k].eg));
    end
    mon_en = 1'b1;

    // 3-beat packet latency and empty on eop.
    do_reset();
    push_pkt(64'hA0, 3, 3'd3);
    fork
      send_pkt(1'b0, 64'hA0, 3, 3'd3);
      begin
        #1;
        chk("lat_ready0", 64'(in0_ready), 64'd0);
        @(negedge clk); #1;
        chk("lat_c1_valid", 64'(to_l8_valid), 64'd0);
        @(negedge clk); #1;
        chk("lat_c2_valid", 64'(to_l8_valid), 64'd1);
        chk("lat_c2_data", to_l8_data, 64'hA0);
      end
    join
    wait_drain();

    // Ties with both sources continuously requesting.
    do_reset();
`ifdef L8_PKT_ARB_STRICT_PRIO_EN
    push_pkt(64'h100, 2, 3'd1);
    push_pkt(64'h300, 1, 3'd5);
    push_pkt(64'h200, 3, 3'd2);
    push_pkt(64'h400, 2, 3'd7);
`else
    push_pkt(64'h100, 2, 3'd1);
    push_pkt(64'h200, 3, 3'd2);
    push_pkt(64'h300, 1, 3'd5);
    push_pkt(64'h400, 2, 3'd7);
`endif
    fork
      begin
        send_pkt(1'b0, 64'h100, 2, 3'd1);
        send_pkt(1'b0, 64'h300, 1, 3'd5);
      end
      begin
        send_pkt(1'b1, 64'h200, 3, 3'd2);
        send_pkt(1'b1, 64'h400, 2, 3'd7);
      end
    join
    wait_drain();

    // Sink backpressure mid-packet for 5 cycles.
    do_reset();
    push_pkt(64'h500, 4, 3'd4);
    fork
      send_pkt(1'b0, 64'h500, 4, 3'd4);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk); #1;
          seen = to_l8_valid && (to_l8_data == 64'h501);
        end
        chk("bp_seen", 64'(seen), 64'd1);
        to_l8_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk); #1;
          chk("bp_data", to_l8_data, 64'h501);
          chk("bp_valid", 64'(to_l8_valid), 64'd1);
          chk("bp_ready0", 64'(in0_ready), 64'd0);
        end
        to_l8_ready = 1'b1;
      end
    join
    wait_drain();

    // Orphan beat on in1 while in0 packet is granted.
    do_reset();
    in1_data = 64'hDEAD; in1_sop = 1'b0; in1_valid = 1'b1;
    push_pkt(64'h600, 2, 3'd0);
    bad = 1'b0;
    fork
      send_pkt(1'b0, 64'h600, 2, 3'd0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); #1;
        if (in1_ready) bad = 1'b1;
      end
    join
    wait_drain();
    chk("orphan_ready1", 64'(bad), 64'd0);
    chk("orphan_grant", 64'(grant_idx), 64'd0);
    in1_valid = 1'b0;

    // Reset during a 4-beat packet, then a clean packet.
    do_reset();
    mon_en = 1'b0;
    send_beat(1'b0, mk(64'h800, 0, 4, 3'd0));
    send_beat(1'b0, mk(64'h800, 1, 4, 3'd0));
    xrst = 1'b0;
    drive(1'b0, '0, 1'b0);
    #1;
    chk("mid_rst_valid", 64'(to_l8_valid), 64'd0);
    chk("mid_rst_ready", {62'd0, in1_ready, in0_ready}, 64'd0);
    @(negedge clk);
    xrst = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    #1;
    chk("post_rst_valid", 64'(to_l8_valid), 64'd0);
    @(negedge clk);
    push_pkt(64'h700, 3, 3'd6);
    send_pkt(1'b0, 64'h700, 3, 3'd6);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
